// File: rtl/cache_ctrl_pkg.sv
// Shared types for the L1 cache sequencing controller: FSM state encoding.
package cache_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    RESPOND  = 3'd5
  } state_e;

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating event counter: counts up by one per cycle with inc high, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through L1 sequencing controller (one outstanding core op).
// Optional hit/miss counters are built when CACHE_CTRL_PERF_EN is defined.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int SET_BIT_WIDTH = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req_valid,
  output logic                  core_req_ready,
  input  logic                  core_req_write,
  input  logic [ADDR_WIDTH-1:0] core_req_addr,
  input  logic [DATA_WIDTH-1:0] core_req_wdata,
  output logic                  core_resp_valid,
  output logic [DATA_WIDTH-1:0] core_resp_rdata,
  output logic                  cache_read_write,
  output logic [ADDR_WIDTH-1:0] cache_inp,
  output logic [DATA_WIDTH-1:0] cache_data_in,
  output logic                  cache_valid_in,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_data_out,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_misses
`endif
);

  if (SET_BIT_WIDTH < 1 || SET_BIT_WIDTH >= ADDR_WIDTH) begin : g_bad_cfg
    $error("cache_ctrl: SET_BIT_WIDTH must be in [1, ADDR_WIDTH-1]");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  write_q, write_d;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    write_d          = write_q;
    core_req_ready   = 1'b0;
    core_resp_valid  = 1'b0;
    core_resp_rdata  = '0;
    cache_read_write = 1'b0;
    cache_data_in    = '0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;

    unique case (state_q)
      IDLE: begin
        core_req_ready = 1'b1;
        if (core_req_valid) begin
          addr_d  = core_req_addr;
          wdata_d = core_req_wdata;
          write_d = core_req_write;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (write_q) begin
          // Write-through with no allocate: update the line only if it is already present.
          if (cache_hit) begin
            cache_read_write = 1'b1;
            cache_data_in    = wdata_q;
          end
          state_d = MEM_REQ;
        end else if (cache_hit) begin
          rdata_d = cache_data_out;
          state_d = RESPOND;
        end else begin
          state_d = MEM_REQ;
        end
      end

      MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = write_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = write_q ? wdata_q : '0;
        if (mem_req_ready) begin
          state_d = MEM_WAIT;
        end
      end

      MEM_WAIT: begin
        if (mem_resp_valid) begin
          if (write_q) begin
            state_d = RESPOND;
          end else begin
            rdata_d = mem_resp_rdata;
            state_d = FILL;
          end
        end
      end

      FILL: begin
        cache_read_write = 1'b1;
        cache_data_in    = rdata_q;
        state_d          = RESPOND;
      end

      RESPOND: begin
        core_resp_valid = 1'b1;
        core_resp_rdata = write_q ? '0 : rdata_q;
        state_d         = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
    end
  end

  assign cache_inp      = addr_q;
  assign cache_valid_in = cache_read_write;

`ifdef CACHE_CTRL_PERF_EN
  logic hit_inc, miss_inc;

  assign hit_inc  = (state_q == LOOKUP) &&  cache_hit;
  assign miss_inc = (state_q == LOOKUP) && !cache_hit;

  sat_counter #(.WIDTH(32)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .count (perf_hits)
  );

  sat_counter #(.WIDTH(32)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .count (perf_misses)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache array and memory, table of core ops, reset abort sequence.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_valid, core_req_ready, core_req_write;
  logic [31:0] core_req_addr, core_req_wdata;
  logic        core_resp_valid;
  logic [31:0] core_resp_rdata;
  logic        cache_read_write, cache_valid_in, cache_hit;
  logic [31:0] cache_inp, cache_data_in, cache_data_out;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  cache_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .core_req_valid   (core_req_valid),
    .core_req_ready   (core_req_ready),
    .core_req_write   (core_req_write),
    .core_req_addr    (core_req_addr),
    .core_req_wdata   (core_req_wdata),
    .core_resp_valid  (core_resp_valid),
    .core_resp_rdata  (core_resp_rdata),
    .cache_read_write (cache_read_write),
    .cache_inp        (cache_inp),
    .cache_data_in    (cache_data_in),
    .cache_valid_in   (cache_valid_in),
    .cache_hit        (cache_hit),
    .cache_data_out   (cache_data_out),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_write    (mem_req_write),
    .mem_req_addr     (mem_req_addr),
    .mem_req_wdata    (mem_req_wdata),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_rdata   (mem_resp_rdata)
`ifdef CACHE_CTRL_PERF_EN
    ,
    .perf_hits        (perf_hits),
    .perf_misses      (perf_misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural 4-line direct-mapped array: combinational read, write on the clock edge.
  logic [29:0] tag_m  [4];
  logic [31:0] data_m [4];
  logic        vld_m  [4];
  logic        arr_clr;

  always_comb begin
    cache_hit      = vld_m[cache_inp[1:0]] && (tag_m[cache_inp[1:0]] == cache_inp[31:2]);
    cache_data_out = data_m[cache_inp[1:0]];
  end

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int i = 0; i < 4; i++) vld_m[i] <= 1'b0;
    end else if (cache_read_write) begin
      tag_m[cache_inp[1:0]]  <= cache_inp[31:2];
      data_m[cache_inp[1:0]] <= cache_data_in;
      vld_m[cache_inp[1:0]]  <= cache_valid_in;
    end
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    int          rdy_dly;
    int          resp_dly;
    logic        exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    exp_t        e;
    exp_t        got;
    int          req_cyc, hs_cyc, writes, hs_cnt, exp_writes, exp_hs;
    logic [31:0] wr_data, exp_wr_data;
    logic        stable, rdy_ok, wr_ok, resp_seen;

    chk({nm, " ready_idle"}, core_req_ready, 1'b1);
    core_req_valid = 1'b1;
    core_req_write = v.write;
    core_req_addr  = v.addr;
    core_req_wdata = v.wdata;
    e.rdata = v.write ? 32'h0 : v.exp_rdata;
    if (!v.write && v.exp_hit) e.lat = 2;
    else if (!v.write)         e.lat = 4 + v.rdy_dly + v.resp_dly;
    else                       e.lat = 3 + v.rdy_dly + v.resp_dly;
    e.acc = cyc_cnt;
    sb_q.push_back(e);
    @(posedge clk); #1;
    // Scramble request inputs so only latched values can satisfy the checks.
    core_req_valid = 1'b0;
    core_req_write = ~v.write;
    core_req_addr  = $urandom;
    core_req_wdata = $urandom;

    hs_cyc = -1; req_cyc = 0; writes = 0; hs_cnt = 0; wr_data = '0;
    stable = 1'b1; rdy_ok = 1'b1; wr_ok = 1'b1; resp_seen = 1'b0;
    for (int k = 0; k < 60 && !resp_seen; k++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      if (mem_req_valid && hs_cyc < 0) begin
        if (mem_req_addr !== v.addr || mem_req_write !== v.write ||
            (v.write && mem_req_wdata !== v.wdata)) stable = 1'b0;
        if (req_cyc == v.rdy_dly) begin
          mem_req_ready = 1'b1;
          hs_cyc        = cyc_cnt;
          hs_cnt++;
        end
        req_cyc++;
      end
      if (hs_cyc >= 0 && cyc_cnt == hs_cyc + v.resp_dly) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = v.mem_data;
      end
      @(negedge clk);
      if (cache_read_write) begin
        writes++;
        wr_data = cache_data_in;
        if (!cache_valid_in || cache_inp !== v.addr) wr_ok = 1'b0;
      end
      if (core_req_ready) rdy_ok = 1'b0;
      if (core_resp_valid) begin
        resp_seen = 1'b1;
        if (sb_q.size() == 0) begin
          chk({nm, " resp_unexpected"}, 32'h1, 32'h0);
        end else begin
          got = sb_q.pop_front();
          chk({nm, " rdata"}, core_resp_rdata, got.rdata);
          chk({nm, " latency"}, cyc_cnt - got.acc, got.lat);
        end
      end
      @(posedge clk); #1;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;

    if (!resp_seen) begin
      chk({nm, " resp_timeout"}, 32'h0, 32'h1);
      sb_q.delete();
    end
    exp_writes  = (v.write == v.exp_hit) ? 1 : 0;
    exp_wr_data = v.write ? v.wdata : v.mem_data;
    exp_hs      = (!v.write && v.exp_hit) ? 0 : 1;
    chk({nm, " cache_writes"}, writes, exp_writes);
    if (exp_writes == 1 && writes == 1) begin
      chk({nm, " cache_wdata"}, wr_data, exp_wr_data);
      chk({nm, " cache_wr_addr_valid"}, wr_ok, 1'b1);
    end
    chk({nm, " mem_handshakes"}, hs_cnt, exp_hs);
    if (exp_hs == 1) chk({nm, " mem_req_fields_stable"}, stable, 1'b1);
    chk({nm, " ready_low_while_busy"}, rdy_ok, 1'b1);
  endtask

  vec_t vecs [10];
  int   n_hits, n_misses;
  int   bad_wr, bad_resp, bad_rdy;

  initial begin
    //              write  addr   wdata         mem_data      rdy rsp hit  exp_rdata
    vecs[0] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        32'h0,        0, 1, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h10, 32'h12345678, 32'h0,        0, 1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h10, 32'h0,        32'h0,        0, 1, 1'b1, 32'h12345678};
    vecs[4] = '{1'b1, 32'h24, 32'hCAFEF00D, 32'h0,        1, 2, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h24, 32'h0,        32'h0BADF00D, 0, 1, 1'b0, 32'h0BADF00D};
    vecs[6] = '{1'b0, 32'h13, 32'h0,        32'h55AA55AA, 5, 2, 1'b0, 32'h55AA55AA};
    vecs[7] = '{1'b0, 32'h10, 32'h0,        32'h11112222, 2, 1, 1'b0, 32'h11112222};
    vecs[8] = '{1'b1, 32'h13, 32'hFFFFFFFF, 32'h0,        0, 1, 1'b1, 32'h0};
    vecs[9] = '{1'b0, 32'h13, 32'h0,        32'h0,        0, 1, 1'b1, 32'hFFFFFFFF};

    rst_n = 1'b0; arr_clr = 1'b1;
    core_req_valid = 1'b0; core_req_write = 1'b0; core_req_addr = '0; core_req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst core_req_ready", core_req_ready, 1'b1);
    chk("rst core_resp_valid", core_resp_valid, 1'b0);
    chk("rst core_resp_rdata", core_resp_rdata, 32'h0);
    chk("rst mem_req_valid", mem_req_valid, 1'b0);
    chk("rst cache_read_write", cache_read_write, 1'b0);
    chk("rst cache_inp", cache_inp, 32'h0);
    chk("rst mem_req_addr", mem_req_addr, 32'h0);
`ifdef CACHE_CTRL_PERF_EN
    chk("rst perf_hits", perf_hits, 32'h0);
    chk("rst perf_misses", perf_misses, 32'h0);
`endif
    rst_n = 1'b1; arr_clr = 1'b0;
    @(posedge clk); #1;

    n_hits = 0; n_misses = 0;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("op%0d", i));
      if (vecs[i].exp_hit) n_hits++;
      else                 n_misses++;
    end
`ifdef CACHE_CTRL_PERF_EN
    chk("perf_hits", perf_hits, n_hits);
    chk("perf_misses", perf_misses, n_misses);
`endif

    // Abort a load miss in MEM_WAIT with reset, then deliver a stale memory response.
    core_req_valid = 1'b1; core_req_write = 1'b0; core_req_addr = 32'h20;
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    for (int k = 0; k < 10 && !mem_req_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("abort mem_req_valid_seen", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort core_req_ready", core_req_ready, 1'b1);
    chk("abort mem_req_valid", mem_req_valid, 1'b0);
    chk("abort cache_read_write", cache_read_write, 1'b0);
    chk("abort core_resp_valid", core_resp_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hA5A5A5A5;
    bad_wr = 0; bad_resp = 0; bad_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cache_read_write) bad_wr++;
      if (core_resp_valid) bad_resp++;
      if (!core_req_ready) bad_rdy++;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
    end
    chk("abort no_fill", bad_wr, 0);
    chk("abort no_resp", bad_resp, 0);
    chk("abort stays_idle", bad_rdy, 0);
`ifdef CACHE_CTRL_PERF_EN
    chk("abort perf_hits", perf_hits, 32'h0);
    chk("abort perf_misses", perf_misses, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the direct-mapped, write-through L1 cache array: accepts one core load/store at a time, performs the tag lookup, and handles misses through a valid/ready memory port.
- Performs line fills and returns the load result to the core.
- Sits between the core's memory stage and the cache array plus the next-level memory.
- The cache array is external: combinational read, write on clock edge.

Parameters:
SET_BIT_WIDTH, 2, index bits; the cache has 2**SET_BIT_WIDTH lines
ADDR_WIDTH, 32, word address width (same as the cache input width)
DATA_WIDTH, 32, data word width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
core_req_valid  in  1  core request present
core_req_ready  out  1  controller can accept a request
core_req_write  in  1  1=store, 0=load
core_req_addr  in  ADDR_WIDTH  word address
core_req_wdata  in  DATA_WIDTH  store data
core_resp_valid  out  1  one-cycle completion pulse
core_resp_rdata  out  DATA_WIDTH  load data (0 for stores)
cache_read_write  out  1  cache line write enable
cache_inp  out  ADDR_WIDTH  address to cache (set = low bits, tag = high bits)
cache_data_in  out  DATA_WIDTH  data written into the line
cache_valid_in  out  1  valid bit written into the line
cache_hit  in  1  cache hit (combinational)
cache_data_out  in  DATA_WIDTH  cache line data (combinational)
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=write-through, 0=fill read
mem_req_addr  out  ADDR_WIDTH  memory address
mem_req_wdata  out  DATA_WIDTH  write-through data
mem_resp_valid  in  1  read data valid or write acknowledge
mem_resp_rdata  in  DATA_WIDTH  fill data

Behaviour:
- One clock domain, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset state: state=IDLE; all outputs 0 except core_req_ready=1; latched addr/wdata/op cleared.
- cache_inp always drives the latched address. cache_valid_in=1 whenever cache_read_write=1.
- IDLE:
  - core_req_ready=1.
  - On core_req_valid, latch addr, wdata and write, then go to LOOKUP.
- LOOKUP (1 cycle): sample cache_hit.
  - Load hit: capture cache_data_out, go to RESPOND.
  - Load miss: go to MEM_REQ (read).
  - Store hit: assert cache_read_write with cache_data_in=wdata this cycle, go to MEM_REQ (write).
  - Store miss: no allocate, go to MEM_REQ (write).
- MEM_REQ:
  - Hold mem_req_valid, mem_req_write, mem_req_addr and mem_req_wdata stable until mem_req_ready. Never drop valid before the handshake.
  - Handshake cycle: go to MEM_WAIT.
- MEM_WAIT:
  - Wait for mem_resp_valid.
  - Load: capture mem_resp_rdata, go to FILL.
  - Store: go to RESPOND.
- FILL (1 cycle): cache_read_write=1, cache_data_in=captured data, then go to RESPOND.
- RESPOND (1 cycle): core_resp_valid=1; core_resp_rdata=captured data for loads, 0 for stores. Then go to IDLE.
- core_req_ready=0 in every state except IDLE. The response carries no backpressure.
- Latency from accept edge to core_resp_valid:
  - load hit: 2 cycles
  - load miss: 4 + memory cycles
  - store: 3 + memory cycles
- mem_resp_valid outside MEM_WAIT is ignored.
- mem_req_ready and mem_resp_valid may arrive in consecutive cycles; a response in the handshake cycle itself is not expected.
- rst_n low in any state aborts the operation immediately: outputs return to reset values and no partial fill occurs.

Optional Feature:
- Macro: CACHE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_hits [31:0] and perf_misses [31:0], reset to 0.
  - Each increments by 1 in LOOKUP on hit or miss respectively, loads and stores alike.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_ctrl_pkg: state enum (IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESPOND) and a state-width constant.
- FSM and datapath latches stay in one module.
- Natural sub-module: sat_counter (parameterised width, saturating increment), instantiated twice under CACHE_CTRL_PERF_EN.

Test Plan:
- Reset then cold load addr 0x10; memory ready same cycle, resp after 3 cycles with 0xDEADBEEF -> fill write to set 0, core_resp_valid with 0xDEADBEEF, 7 cycles after accept.
- Reload 0x10 -> no mem_req_valid; core_resp_rdata=0xDEADBEEF 2 cycles after accept.
- Store 0x10 data 0x12345678 (hit) -> cache write in LOOKUP; mem write to 0x10 with 0x12345678; response after ack. A following load 0x10 hits with 0x12345678.
- Store miss to 0x24, then load 0x24 -> no cache write on the store; the load misses and issues a memory read.
- Load miss with mem_req_ready held low 5 cycles -> mem_req_valid/addr stable all 5 cycles; core_req_ready stays 0 until RESPOND completes.
- rst_n pulsed low during MEM_WAIT, then a late mem_resp_valid -> state IDLE, no cache write, no core_resp_valid. With CACHE_CTRL_PERF_EN, counters read 0.
